// File: rtl/vga_sync_timing_if.sv
// Raster outputs of the VGA timing generator, consumed by the character/graphics generator.
interface vga_sync_timing_if;
   logic       p_tick;
   logic [9:0] pix_x;
   logic [9:0] pix_y;
   logic       hsync;
   logic       vsync;
   logic       video_on;
   logic       frame_start;

   modport master (
      output p_tick, pix_x, pix_y, hsync, vsync, video_on, frame_start
   );

   modport slave (
      input  p_tick, pix_x, pix_y, hsync, vsync, video_on, frame_start
   );
endinterface

// File: rtl/vga_sync_timing.sv
// 640x480@60 VGA raster generator: pixel tick, h/v counters, and sync/video flags
// delayed PIPE_DLY ticks to line up with the generator's registered RGB.
module vga_sync_timing #(
   parameter int TICK_DIV  = 1,
   parameter int H_DISPLAY = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_DISPLAY = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33,
   parameter int PIPE_DLY  = 2
) (
   input  logic               CLK,
   input  logic               RESET,
   vga_sync_timing_if.master  vga
);

   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam int DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef struct packed {
      logic hs;
      logic vs;
      logic vo;
   } sync_t;

   localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, vo: 1'b0};

   logic [DIV_W-1:0] div_q, div_d;
   logic             p_tick_q;
   logic             run_q;
   logic             frame_q;
   logic [9:0]       h_q, h_d;
   logic [9:0]       v_q, v_d;
   logic             h_end, v_end;
   sync_t            raw;
   sync_t            sync_out;

   always_comb begin
      div_d = (div_q == DIV_W'(TICK_DIV - 1)) ? '0 : div_q + DIV_W'(1);
      h_end = (h_q == 10'(H_TOTAL - 1));
      v_end = (v_q == 10'(V_TOTAL - 1));
      h_d   = h_q;
      v_d   = v_q;
      if (p_tick_q) begin
         h_d = h_end ? '0 : h_q + 10'd1;
         if (h_end) v_d = v_end ? '0 : v_q + 10'd1;
      end
   end

   // run_q keeps video_on low through reset even when there is no delay line
   always_comb begin
      raw.hs = !((h_q >= 10'(H_DISPLAY + H_FRONT)) &&
                 (h_q <= 10'(H_DISPLAY + H_FRONT + H_SYNC - 1)));
      raw.vs = !((v_q >= 10'(V_DISPLAY + V_FRONT)) &&
                 (v_q <= 10'(V_DISPLAY + V_FRONT + V_SYNC - 1)));
      raw.vo = run_q && (h_q < 10'(H_DISPLAY)) && (v_q < 10'(V_DISPLAY));
   end

   // p_tick is registered from the next divider value so it stays low in reset
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         div_q    <= '0;
         p_tick_q <= 1'b0;
         run_q    <= 1'b0;
         h_q      <= '0;
         v_q      <= '0;
         frame_q  <= 1'b0;
      end else begin
         div_q    <= div_d;
         p_tick_q <= (div_d == DIV_W'(TICK_DIV - 1));
         run_q    <= 1'b1;
         h_q      <= h_d;
         v_q      <= v_d;
         frame_q  <= p_tick_q && h_end && v_end;
      end
   end

   generate
      if (PIPE_DLY == 0) begin : g_nodly
         assign sync_out = raw;
      end else begin : g_dly
         sync_t [PIPE_DLY-1:0] pipe_q;

         always_ff @(posedge CLK or negedge RESET) begin
            if (!RESET) begin
               for (int i = 0; i < PIPE_DLY; i++) pipe_q[i] <= SYNC_IDLE;
            end else if (p_tick_q) begin
               pipe_q[0] <= raw;
               for (int i = 1; i < PIPE_DLY; i++) pipe_q[i] <= pipe_q[i-1];
            end
         end

         assign sync_out = pipe_q[PIPE_DLY-1];
      end
   endgenerate

   assign vga.p_tick      = p_tick_q;
   assign vga.pix_x       = h_q;
   assign vga.pix_y       = v_q;
   assign vga.hsync       = sync_out.hs;
   assign vga.vsync       = sync_out.vs;
   assign vga.video_on    = sync_out.vo;
   assign vga.frame_start = frame_q;

endmodule

// File: tb/tb_vga_sync_timing.sv
// Directed bench: default raster at delays 0/2/7, TICK_DIV=4, and a shrunken raster
// (32x20 totals) so full frames and a mid-frame reset fit in a short run.
module tb_vga_sync_timing;

   logic CLK   = 1'b0;
   logic RESET = 1'b0;
   int   n_vec  = 0;
   int   n_miss = 0;

   always #5 CLK = ~CLK;

   vga_sync_timing_if if_d0 ();
   vga_sync_timing_if if_d2 ();
   vga_sync_timing_if if_d7 ();
   vga_sync_timing_if if_t4 ();
   vga_sync_timing_if if_sm ();

   vga_sync_timing #(.TICK_DIV(1), .PIPE_DLY(0)) u_d0 (.CLK(CLK), .RESET(RESET), .vga(if_d0));
   vga_sync_timing #(.TICK_DIV(1), .PIPE_DLY(2)) u_d2 (.CLK(CLK), .RESET(RESET), .vga(if_d2));
   vga_sync_timing #(.TICK_DIV(1), .PIPE_DLY(7)) u_d7 (.CLK(CLK), .RESET(RESET), .vga(if_d7));
   vga_sync_timing #(.TICK_DIV(4), .PIPE_DLY(2)) u_t4 (.CLK(CLK), .RESET(RESET), .vga(if_t4));
   vga_sync_timing #(
      .TICK_DIV(1), .H_DISPLAY(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
      .V_DISPLAY(12), .V_FRONT(3), .V_SYNC(2), .V_BACK(3), .PIPE_DLY(2)
   ) u_sm (.CLK(CLK), .RESET(RESET), .vga(if_sm));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Runs n cycles from a reset release (released at a negedge) and checks the raster.
   task automatic run_window(input int n);
      int   d0_bad = 0, p0_low = 0, d0_hfall = -1, d2_hfall = -1;
      int   d2_hlow = 0, d2_vohi = 0;
      int   rise[3], fall[3];
      logic pv[3], cv[3];
      int   p4_cnt = 0, p4_last = -1, p4_gap_bad = 0, t4_hlow = 0, t4_rise = -1;
      int   fs_cnt = 0, fs_first = -1, fs_last = -1, fs_gap_bad = 0, fs_pos_bad = 0;
      int   sm_vlow = 0, sm_vf_y = -1, sm_vf_x = -1;
      for (int j = 0; j < 3; j++) begin
         rise[j] = -1; fall[j] = -1; pv[j] = 1'b0;
      end
      for (int k = 1; k <= n; k++) begin
         tick();
         if (if_d0.pix_x !== 10'((k-1) % 800) || if_d0.pix_y !== 10'((k-1) / 800)) d0_bad++;
         if (if_d0.p_tick !== 1'b1) p0_low++;
         if (k == 800) begin
            chk("d0_x_799", if_d0.pix_x, 799);
            chk("d0_y_line0", if_d0.pix_y, 0);
         end
         if (k == 801) begin
            chk("d0_x_wrap", if_d0.pix_x, 0);
            chk("d0_y_step", if_d0.pix_y, 1);
         end
         if (d0_hfall < 0 && if_d0.hsync === 1'b0) d0_hfall = int'(if_d0.pix_x);
         if (d2_hfall < 0 && if_d2.hsync === 1'b0) d2_hfall = int'(if_d2.pix_x);
         if (if_d2.pix_y == 10'd0 && if_d2.hsync === 1'b0)   d2_hlow++;
         if (if_d2.pix_y == 10'd0 && if_d2.video_on === 1'b1) d2_vohi++;
         cv[0] = if_d0.video_on; cv[1] = if_d2.video_on; cv[2] = if_d7.video_on;
         for (int j = 0; j < 3; j++) begin
            if (rise[j] < 0 && pv[j] === 1'b0 && cv[j] === 1'b1) rise[j] = int'(if_d0.pix_x);
            if (fall[j] < 0 && pv[j] === 1'b1 && cv[j] === 1'b0) fall[j] = int'(if_d0.pix_x);
            pv[j] = cv[j];
         end
         if (if_t4.p_tick === 1'b1) begin
            p4_cnt++;
            if (p4_last >= 0 && k - p4_last != 4) p4_gap_bad++;
            p4_last = k;
         end
         if (if_t4.pix_y == 10'd0 && if_t4.hsync === 1'b0) t4_hlow++;
         if (t4_rise < 0 && if_t4.video_on === 1'b1) t4_rise = int'(if_t4.pix_x);
         if (k == 3199) begin
            chk("t4_x_799", if_t4.pix_x, 799);
            chk("t4_y_line0", if_t4.pix_y, 0);
         end
         if (k == 3200) begin
            chk("t4_x_wrap", if_t4.pix_x, 0);
            chk("t4_y_step", if_t4.pix_y, 1);
         end
         if (if_sm.frame_start === 1'b1) begin
            fs_cnt++;
            if (fs_first < 0) fs_first = k;
            if (fs_last >= 0 && k - fs_last != 640) fs_gap_bad++;
            fs_last = k;
            if (if_sm.pix_x != 10'd0 || if_sm.pix_y != 10'd0) fs_pos_bad++;
         end
         if (k <= 640 && if_sm.vsync === 1'b0) begin
            sm_vlow++;
            if (sm_vf_y < 0) begin
               sm_vf_y = int'(if_sm.pix_y);
               sm_vf_x = int'(if_sm.pix_x);
            end
         end
      end
      chk("d0_count_seq", d0_bad, 0);
      chk("d0_ptick_low", p0_low, 0);
      chk("d0_hs_fall_x", d0_hfall, 656);
      chk("d2_hs_fall_x", d2_hfall, 658);
      chk("d2_hs_width", d2_hlow, 96);
      chk("d2_vo_width", d2_vohi, 640);
      chk("d0_vo_rise", rise[0], 0);
      chk("d2_vo_rise", rise[1], 2);
      chk("d7_vo_rise", rise[2], 7);
      chk("d0_vo_fall", fall[0], 640);
      chk("d2_vo_fall", fall[1], 642);
      chk("d7_vo_fall", fall[2], 647);
      chk("t4_ptick_cnt", p4_cnt, 825);
      chk("t4_ptick_gap", p4_gap_bad, 0);
      chk("t4_hs_clks", t4_hlow, 384);
      chk("t4_vo_rise", t4_rise, 2);
      chk("sm_fs_cnt", fs_cnt, 5);
      chk("sm_fs_first", fs_first, 641);
      chk("sm_fs_gap", fs_gap_bad, 0);
      chk("sm_fs_pos", fs_pos_bad, 0);
      chk("sm_vs_width", sm_vlow, 64);
      chk("sm_vs_fall_y", sm_vf_y, 15);
      chk("sm_vs_fall_x", sm_vf_x, 2);
   endtask

   task automatic chk_reset_outs(input string who);
      chk({who, "_rst_ptick"}, if_d0.p_tick, 0);
      chk({who, "_rst_t4ptick"}, if_t4.p_tick, 0);
      chk({who, "_rst_x"}, if_d2.pix_x, 0);
      chk({who, "_rst_y"}, if_d2.pix_y, 0);
      chk({who, "_rst_hs"}, if_d2.hsync, 1);
      chk({who, "_rst_vs"}, if_d2.vsync, 1);
      chk({who, "_rst_vo"}, if_d2.video_on, 0);
      chk({who, "_rst_vo0"}, if_d0.video_on, 0);
      chk({who, "_rst_vo7"}, if_d7.video_on, 0);
      chk({who, "_rst_fs"}, if_d2.frame_start, 0);
      chk({who, "_rst_smx"}, if_sm.pix_x, 0);
      chk({who, "_rst_smy"}, if_sm.pix_y, 0);
      chk({who, "_rst_smhs"}, if_sm.hsync, 1);
      chk({who, "_rst_smvs"}, if_sm.vsync, 1);
   endtask

   initial begin
      int found;
      RESET = 1'b0;
      repeat (3) tick();
      chk_reset_outs("por");
      @(negedge CLK) RESET = 1'b1;
      run_window(3300);

      // Default raster: reset in the middle of hsync
      found = 0;
      for (int i = 0; i < 2000 && found == 0; i++) begin
         tick();
         if (if_d2.pix_x == 10'd700) found = 1;
      end
      chk("d2_reach_700", found, 1);
      chk("d2_hs_mid", if_d2.hsync, 0);
      #2 RESET = 1'b0;
      #1 chk_reset_outs("mid");
      repeat (2) tick();
      @(negedge CLK) RESET = 1'b1;
      run_window(3300);

      // Small raster: reset at (23,10), inside its hsync
      found = 0;
      for (int i = 0; i < 1000 && found == 0; i++) begin
         tick();
         if (if_sm.pix_y == 10'd10 && if_sm.pix_x == 10'd23) found = 1;
      end
      chk("sm_reach_pos", found, 1);
      chk("sm_hs_mid", if_sm.hsync, 0);
      #2 RESET = 1'b0;
      #1 chk_reset_outs("smid");
      repeat (2) tick();
      @(negedge CLK) RESET = 1'b1;
      run_window(3300);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected summary");
      $fatal(1, "simulation timeout");
   end

endmodule
